// File: rtl/aes_key_expander.sv
// -----------------------------------------------------------------------------
// aes_key_expander
//   Iterative AES-128 key schedule. On an accepted start the cipher key is
//   loaded and round keys 0..NR are emitted on NR+1 consecutive cycles, one
//   per clock, ready to be loaded into the encipher's round-key store.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous, active-low reset
//   start        in   expansion request; sampled only while ready is high
//   key_in[127:0] in  cipher key, MSB = first key byte
//   ready        out  high in IDLE (start accepted this cycle)
//   rk_round[3:0] out round index of rk_data
//   rk_data[127:0] out round key
//   rk_valid     out  rk_round/rk_data valid this cycle
//   done         out  one-cycle pulse with the last round key (rk_round == NR)
//   o_dbg_state  out  current FSM state (0 = IDLE, 1 = EXPAND)
//
// Handshake: start is accepted on a rising edge where start & ready are both
// high. ready is held low for the whole expansion, so start is ignored then.
// rk_valid has no back-pressure: the consumer must take every key the cycle
// it is presented.
// -----------------------------------------------------------------------------

// AES S-box applied independently to NBYTES bytes.
module aes_sbox #(
  parameter int NBYTES = 4
) (
  input  logic [8*NBYTES-1:0] i_data,
  output logic [8*NBYTES-1:0] o_data
);

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  for (genvar g = 0; g < NBYTES; g++) begin : g_byte
    assign o_data[8*g +: 8] = SBOX[i_data[8*g +: 8]];
  end

endmodule

module aes_key_expander #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         ready,
  output logic [3:0]   rk_round,
  output logic [127:0] rk_data,
  output logic         rk_valid,
  output logic         done,
  output logic         o_dbg_state
);

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_EXPAND = 1'b1
  } state_t;

  state_t       r_state;
  logic [3:0]   r_cnt;
  logic [3:0]   r_rk_round;
  logic         r_rk_valid;
  logic         r_done;
  logic         r_ready;
  logic [127:0] r_w;
  logic [127:0] r_rk_data;
  logic [7:0]   r_rcon;

  logic         w_accept;
  logic         w_step;
  logic [31:0]  w_rot;
  logic [31:0]  w_sub;
  logic [31:0]  w_t;
  logic [31:0]  w_n0, w_n1, w_n2, w_n3;
  logic [127:0] w_next;
  logic [7:0]   w_rcon_next;

  // r_ready mirrors r_state == S_IDLE, so accepting on it is the same as
  // sampling start only in IDLE.
  assign w_accept = start & r_ready;
  // A new round key is produced every EXPAND cycle except the one already
  // showing round NR.
  assign w_step   = (r_state == S_EXPAND) && (r_cnt != LAST_ROUND);

  // RotWord of w3 (the least significant word of the working register).
  assign w_rot = {r_w[23:0], r_w[31:24]};

  aes_sbox #(
    .NBYTES(4)
  ) u_sbox (
    .i_data(w_rot),
    .o_data(w_sub)
  );

  assign w_t    = w_sub ^ {r_rcon, 24'h0};
  assign w_n0   = r_w[127:96] ^ w_t;
  assign w_n1   = r_w[95:64]  ^ w_n0;
  assign w_n2   = r_w[63:32]  ^ w_n1;
  assign w_n3   = r_w[31:0]   ^ w_n2;
  assign w_next = {w_n0, w_n1, w_n2, w_n3};

  // GF(2^8) doubling; r_rcon always holds the constant for the next round.
  assign w_rcon_next = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

  // Control FSM: state, round counter and all handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_rk_round <= 4'd0;
      r_rk_valid <= 1'b0;
      r_done     <= 1'b0;
      r_ready    <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_state    <= S_EXPAND;
            r_cnt      <= 4'd0;
            r_rk_round <= 4'd0;
            r_rk_valid <= 1'b1;
            r_done     <= (LAST_ROUND == 4'd0);
            r_ready    <= 1'b0;
          end else begin
            r_rk_valid <= 1'b0;
            r_ready    <= 1'b1;
          end
        end
        S_EXPAND: begin
          if (r_cnt == LAST_ROUND) begin
            // Round NR is on the outputs this cycle; drop back to IDLE.
            r_state    <= S_IDLE;
            r_rk_valid <= 1'b0;
            r_done     <= 1'b0;
            r_ready    <= 1'b1;
          end else begin
            r_cnt      <= r_cnt + 4'd1;
            r_rk_round <= r_cnt + 4'd1;
            r_rk_valid <= 1'b1;
            r_done     <= ((r_cnt + 4'd1) == LAST_ROUND);
            r_ready    <= 1'b0;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_rk_valid <= 1'b0;
          r_done     <= 1'b0;
          r_ready    <= 1'b1;
        end
      endcase
    end
  end

  // Key datapath: no reset needed, its contents are only observed while
  // rk_valid is high, which the control block gates.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_w       <= key_in;
      r_rk_data <= key_in;
      r_rcon    <= 8'h01;
    end else if (w_step) begin
      r_w       <= w_next;
      r_rk_data <= w_next;
      r_rcon    <= w_rcon_next;
    end
  end

  assign ready       = r_ready;
  assign rk_round    = r_rk_round;
  assign rk_data     = r_rk_data;
  assign rk_valid    = r_rk_valid;
  assign done        = r_done;
  assign o_dbg_state = r_state;

endmodule

// File: doc/aes_key_expander.md
AES_KEY_EXPANDER -- requirements
Module: aes_key_expander

Interface
REQ-001 SHALL have parameter NR, default 10, number of AES-128 rounds (round keys 0..NR emitted).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset: asynchronous, active-low.
REQ-004 SHALL have port start  input  1  single-cycle request to expand key_in; sampled only in IDLE.
REQ-005 SHALL have port key_in  input  128  AES-128 cipher key, MSB = first key byte, sampled on accepted start.
REQ-006 SHALL have port ready  output  1  high in IDLE, i.e. start will be accepted this cycle.
REQ-007 SHALL have port rk_round  output  4  round index of rk_data; connects to encipher init_round.
REQ-008 SHALL have port rk_data  output  128  round key; connects to encipher init_roundkey.
REQ-009 SHALL have port rk_valid  output  1  rk_round/rk_data valid this cycle; connects to encipher init_roundkey_valid.
REQ-010 SHALL have port done  output  1  one-cycle pulse coincident with the last round key (rk_round == NR).

Function
REQ-011 SHALL implement FSM states IDLE and EXPAND; IDLE -> EXPAND on start & ready; EXPAND -> IDLE after the cycle emitting round NR.
REQ-012 SHALL, on an accepted start, latch key_in into a 128-bit working register w0..w3 (w0 = bits 127:96) and clear the round counter to 0.
REQ-013 SHALL emit exactly NR+1 round keys on NR+1 consecutive cycles, first one the cycle after start is accepted; rk_round = 0,1,...,NR in order.
REQ-014 SHALL output round 0 key equal to key_in unchanged.
REQ-015 SHALL compute round r+1 from round r in one cycle: t = SubWord(RotWord(w3)) ^ {rcon[r+1],24'h0}; w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
REQ-016 SHALL use RotWord({a,b,c,d}) = {b,c,d,a} and SubWord = AES S-box on each byte, through the codebase aes_sbox instance (only the 32 used bits significant).
REQ-017 SHALL generate rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36 by GF(2^8) doubling (x*2 ^ 1b when msb set) starting from 01; no table wrap beyond round 10.
REQ-018 SHALL hold ready low for the entire EXPAND state and ignore start while EXPAND; a start arriving in the cycle EXPAND returns to IDLE is ignored (ready still low).
REQ-019 SHALL accept a new start the first cycle ready is high again; minimum start-to-start spacing NR+2 cycles.
REQ-020 SHALL hold rk_valid low and rk_data/rk_round at their last values in IDLE; rk_data is don't-care when rk_valid low.
REQ-021 SHALL assert done only together with rk_valid and rk_round == NR, for exactly one cycle.
REQ-022 SHALL keep the round counter 4 bits wide; it never exceeds NR.

Reset
REQ-023 SHALL, on rst low, asynchronously force state IDLE, round counter 0, rk_valid 0, done 0, rk_round 0, ready 1 after release.
REQ-024 SHALL, on reset during EXPAND, abort the expansion with no further rk_valid; key registers need no reset value.
REQ-025 SHALL resume normal operation on the first rising clk edge after rst deasserts.

Verification
REQ-026 SHALL pass: key 2b7e151628aed2a6abf7158809cf4f3c, start -> round0 = key, round1 a0fafe1788542cb123a339392a6c7605, round10 d014f9a8c9ee2589e13f0cc8b6630ca6 with done.
REQ-027 SHALL pass: key all-zero -> round1 62636363626363636263636362636363, round10 b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-028 SHALL pass: start held high for 20 cycles -> exactly one expansion of 11 rk_valid cycles, second begins only after ready re-asserts, rk_round sequence 0..10 each time.
REQ-029 SHALL pass: rst pulsed low when rk_round == 5 -> rk_valid and done drop immediately, no further keys; next start produces full correct 0..10 sequence.
REQ-030 SHALL pass: expander connected to aes_encipher, FIPS-197 key, plaintext 3243f6a8885a308d313198a2e0370734 -> ciphertext 3925841d02dc09fbdc118597196a0b32.
